vga_timing_gen: RTL

Pixel-timing generator for the 640x480 @ 60 Hz display path. Free-running horizontal and vertical counters produce `DrawX`/`DrawY`, the active-video `blank` flag and the `hs`/`vs` sync pulses. These drive every sprite mapper and the VGA pins. It also emits a one-cycle end-of-frame strobe that game logic uses to update object positions between frames.

---
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing generator for the 640x480 @ 60 Hz display path. Two
// free-running counters (hc: pixel within line, vc: line within frame)
// provide the current draw position. The sync, blank and frame_end outputs
// are registered from the counters' next-state values, so each one lines up
// with the DrawX/DrawY it describes and cannot glitch.
//
// Optional feature (compile-time macro VGA_SYNC_DELAY_EN):
//   When defined, hs, vs and blank pass through an extra 2-stage register
//   pipeline. This aligns them with pixel colour from a mapper that has a
//   1-cycle ROM read plus a 1-cycle output register. DrawX, DrawY and
//   frame_end are not delayed. In this mode the pipelined reset values are
//   hs = 1, vs = 1, blank = 0.
//   When undefined, every output is coincident with DrawX/DrawY.
//
// Ports:
//   vga_clk   in   25 MHz pixel clock; the only clock
//   reset     in   asynchronous, active-high reset
//   DrawX     out  [9:0] current horizontal pixel count
//   DrawY     out  [9:0] current line count
//   hs        out  horizontal sync, active-low
//   vs        out  vertical sync, active-low
//   blank     out  1 = active video, 0 = blanking
//   sync      out  composite sync, tied to 0
//   frame_end out  one-cycle pulse on the last clock of each frame
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       frame_end
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Both totals must fit the 10-bit counters.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  // Region boundaries widened to 11 bits so an end bound of 1024 stays exact.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic        r_frame_end;

  logic        w_h_last;
  logic        w_v_last;
  logic [9:0]  w_hc_nxt;
  logic [9:0]  w_vc_nxt;
  logic [10:0] w_hc_nxt_ext;
  logic [10:0] w_vc_nxt_ext;
  logic        w_hs_nxt;
  logic        w_vs_nxt;
  logic        w_blank_nxt;
  logic        w_frame_end_nxt;

  // -------------------------------------------------------------------------
  // Next-state counter values
  // -------------------------------------------------------------------------
  always_comb begin
    w_h_last = (r_hc == H_LAST);
    w_v_last = (r_vc == V_LAST);
    w_hc_nxt = r_hc + 10'd1;
    w_vc_nxt = r_vc;
    if (w_h_last) begin
      w_hc_nxt = '0;
      w_vc_nxt = w_v_last ? '0 : (r_vc + 10'd1);
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from next-state counters. Registering these makes each
  // output describe the same pixel as the counters after the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    w_hc_nxt_ext    = {1'b0, w_hc_nxt};
    w_vc_nxt_ext    = {1'b0, w_vc_nxt};
    w_hs_nxt        = !((w_hc_nxt_ext >= HS_START) && (w_hc_nxt_ext < HS_END));
    w_vs_nxt        = !((w_vc_nxt_ext >= VS_START) && (w_vc_nxt_ext < VS_END));
    w_blank_nxt     = (w_hc_nxt_ext < H_VIS) && (w_vc_nxt_ext < V_VIS);
    w_frame_end_nxt = (w_hc_nxt == H_LAST) && (w_vc_nxt == V_LAST);
  end

  // -------------------------------------------------------------------------
  // Counter and registered-output state
  // -------------------------------------------------------------------------
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc        <= '0;
      r_vc        <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_blank     <= 1'b1;   // pixel (0,0) is visible
      r_frame_end <= 1'b0;
    end else begin
      r_hc        <= w_hc_nxt;
      r_vc        <= w_vc_nxt;
      r_hs        <= w_hs_nxt;
      r_vs        <= w_vs_nxt;
      r_blank     <= w_blank_nxt;
      r_frame_end <= w_frame_end_nxt;
    end
  end

  assign DrawX     = r_hc;
  assign DrawY     = r_vc;
  assign frame_end = r_frame_end;
  assign sync      = 1'b0;

`ifdef VGA_SYNC_DELAY_EN
  // Two-stage delay matching a mapper's ROM read plus its output register.
  // Bit [1] is the stage seen by the pins.
  logic [1:0] r_hs_dly;
  logic [1:0] r_vs_dly;
  logic [1:0] r_blank_dly;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hs_dly    <= '1;
      r_vs_dly    <= '1;
      r_blank_dly <= '0;
    end else begin
      r_hs_dly    <= {r_hs_dly[0],    r_hs};
      r_vs_dly    <= {r_vs_dly[0],    r_vs};
      r_blank_dly <= {r_blank_dly[0], r_blank};
    end
  end

  assign hs    = r_hs_dly[1];
  assign vs    = r_vs_dly[1];
  assign blank = r_blank_dly[1];
`else
  assign hs    = r_hs;
  assign vs    = r_vs;
  assign blank = r_blank;
`endif

endmodule
